// File: rtl/maxpool_stream_if.sv
// Pixel stream handshake bundle for the 2x2 max-pool block: conv-side input
// stream and pooled output stream, each a valid/ready pair.
interface maxpool_stream_if #(
  parameter int IntSize = 8
);
  logic                      in_valid;
  logic                      in_ready;
  logic signed [IntSize-1:0] in_data;
  logic                      out_valid;
  logic                      out_ready;
  logic signed [IntSize-1:0] out_data;
  logic                      out_last;
  logic                      frame_done;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, frame_done
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, frame_done
  );
endinterface

// File: rtl/maxpool_stream.sv
// Streaming 2x2/stride-2 signed max-pool over a raster-ordered frame, with a
// half-width line buffer holding the horizontal pair maxima of each even row.
module maxpool_stream #(
  parameter int IntSize = 8,
  parameter int IMG_W   = 28,
  parameter int IMG_H   = 28,
  parameter int RELU    = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  maxpool_stream_if.slave  s
);

  localparam int COL_W  = $clog2(IMG_W);
  localparam int ROW_W  = $clog2(IMG_H);
  localparam int HALF_W = IMG_W / 2;
  localparam int LB_AW  = (HALF_W > 1) ? $clog2(HALF_W) : 1;

  function automatic logic signed [IntSize-1:0] smax(
    input logic signed [IntSize-1:0] a,
    input logic signed [IntSize-1:0] b
  );
    return (b > a) ? b : a;
  endfunction

  function automatic logic signed [IntSize-1:0] relu(
    input logic signed [IntSize-1:0] v
  );
    if (RELU != 0 && v[IntSize-1]) return '0;
    return v;
  endfunction

  logic [COL_W-1:0]          col;
  logic [ROW_W-1:0]          row;
  logic signed [IntSize-1:0] hold_p0;
  logic signed [IntSize-1:0] linebuf [HALF_W];

  logic signed [IntSize-1:0] pair_p0;
  logic signed [IntSize-1:0] lb_rd_p0;
  logic signed [IntSize-1:0] win_p0;
  logic [LB_AW-1:0]          lb_idx;
  logic                      acc;
  logic                      out_fire;
  logic                      col_end;
  logic                      row_end;

  logic                      vld_p1;
  logic                      last_p1;
  logic                      done_p1;
  logic signed [IntSize-1:0] data_p1;

  // Accepting a pixel is only allowed when the output register is free or
  // draining this cycle, so a load can never overwrite a stalled result.
  assign s.in_ready = !clr && (!vld_p1 || s.out_ready);
  assign acc        = s.in_valid && s.in_ready;
  assign out_fire   = vld_p1 && s.out_ready;
  assign col_end    = (col == COL_W'(IMG_W - 1));
  assign row_end    = (row == ROW_W'(IMG_H - 1));
  assign lb_idx     = LB_AW'(col >> 1);

  // ---- stage p0: horizontal pair, line-buffer read, window max ----
  assign pair_p0  = smax(hold_p0, s.in_data);
  assign lb_rd_p0 = linebuf[lb_idx];
  assign win_p0   = relu(smax(lb_rd_p0, pair_p0));

  always_ff @(posedge clk) begin
    if (acc && col[0] && !row[0]) begin
      linebuf[lb_idx] <= pair_p0;
    end
  end

  // ---- stage p1: output register and frame bookkeeping ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col     <= '0;
      row     <= '0;
      hold_p0 <= '0;
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      done_p1 <= 1'b0;
      data_p1 <= '0;
    end else if (clr) begin
      col     <= '0;
      row     <= '0;
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      done_p1 <= 1'b0;
    end else begin
      done_p1 <= out_fire && last_p1;
      if (out_fire) begin
        vld_p1  <= 1'b0;
        last_p1 <= 1'b0;
      end
      if (acc) begin
        if (col_end) begin
          col <= '0;
          row <= row_end ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
        if (!col[0]) begin
          hold_p0 <= s.in_data;
        end else if (row[0]) begin
          data_p1 <= win_p0;
          vld_p1  <= 1'b1;
          last_p1 <= row_end && col_end;
        end
      end
    end
  end

  assign s.out_valid  = vld_p1;
  assign s.out_data   = data_p1;
  assign s.out_last   = last_p1;
  assign s.frame_done = done_p1;

endmodule

// File: tb/tb_maxpool_stream.sv
// Bench for maxpool_stream: signed 2x2 window table, 4x4 ramp/stall/abort
// sequences, and a randomized 28x28 two-frame run against a pooling model.
module tb_maxpool_stream;

  typedef logic signed [7:0] px_t;
  typedef px_t px_q_t[$];

  typedef struct {
    px_t p0, p1, p2, p3;
    px_t e0, e1;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic clr4, clr28;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  maxpool_stream_if #(.IntSize(8)) if4 ();
  maxpool_stream_if #(.IntSize(8)) if2a ();
  maxpool_stream_if #(.IntSize(8)) if2b ();
  maxpool_stream_if #(.IntSize(8)) if28 ();

  logic w2_valid, w2_ready;
  px_t  w2_data;
  assign if2a.in_valid  = w2_valid;
  assign if2a.in_data   = w2_data;
  assign if2a.out_ready = w2_ready;
  assign if2b.in_valid  = w2_valid;
  assign if2b.in_data   = w2_data;
  assign if2b.out_ready = w2_ready;

  maxpool_stream #(.IntSize(8), .IMG_W(4), .IMG_H(4), .RELU(0)) u4 (
    .clk(clk), .reset(reset), .clr(clr4), .s(if4));
  maxpool_stream #(.IntSize(8), .IMG_W(2), .IMG_H(2), .RELU(0)) u2a (
    .clk(clk), .reset(reset), .clr(1'b0), .s(if2a));
  maxpool_stream #(.IntSize(8), .IMG_W(2), .IMG_H(2), .RELU(1)) u2b (
    .clk(clk), .reset(reset), .clr(1'b0), .s(if2b));
  maxpool_stream #(.IntSize(8), .IMG_W(28), .IMG_H(28), .RELU(0)) u28 (
    .clk(clk), .reset(reset), .clr(clr28), .s(if28));

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic px_t max2(input px_t a, input px_t b);
    return (a > b) ? a : b;
  endfunction

  function automatic vec_t mkv(input int a, input int b, input int c, input int d,
                               input int e0, input int e1);
    vec_t v;
    v.p0 = 8'(a); v.p1 = 8'(b); v.p2 = 8'(c); v.p3 = 8'(d);
    v.e0 = 8'(e0); v.e1 = 8'(e1);
    return v;
  endfunction

  // 4x4 output monitor; handshakes seen at a falling edge complete at the next rising edge
  px_q_t got4;
  bit    lastf4[$];
  int    cyc = 0, done4_cnt = 0, done4_cyc = -1, last4_cyc = -2, acc4 = 0;
  bit    stall4 = 0;
  px_t   held4;

  always @(negedge clk) begin
    cyc++;
    if (!reset && !clr4) begin
      if (if4.frame_done) begin
        done4_cnt++;
        done4_cyc = cyc;
      end
      if (stall4) begin
        chk("stable4_valid", if4.out_valid, 1);
        chk("stable4_data", if4.out_data, held4);
      end
      if (if4.out_valid && if4.out_ready) begin
        got4.push_back(if4.out_data);
        lastf4.push_back(if4.out_last);
        if (if4.out_last) last4_cyc = cyc;
      end
      stall4 = if4.out_valid && !if4.out_ready;
      held4  = if4.out_data;
    end else begin
      stall4 = 0;
    end
  end

  // 28x28 scoreboard
  px_q_t exp28;
  bit    explast28[$];
  int    n_out28 = 0, done28 = 0;
  bit    stall28 = 0;
  px_t   held28;

  always @(negedge clk) begin
    if (!reset && !clr28) begin
      if (if28.frame_done) done28++;
      if (stall28) begin
        chk("stall28_valid", if28.out_valid, 1);
        chk("stall28_data", if28.out_data, held28);
      end
      if (if28.out_valid && if28.out_ready) begin
        if (exp28.size() == 0) begin
          chk("out28_extra", n_out28, 392);
        end else begin
          chk("out28_data", if28.out_data, exp28.pop_front());
          chk("out28_last", if28.out_last, explast28.pop_front());
        end
        n_out28++;
      end
      stall28 = if28.out_valid && !if28.out_ready;
      held28  = if28.out_data;
    end else begin
      stall28 = 0;
    end
  end

  task automatic feed4(input px_q_t px);
    int  i = 0;
    int  n = 0;
    bit  a;
    while (i < px.size() && n < 500) begin
      if4.in_valid = 1'b1;
      if4.in_data  = px[i];
      @(negedge clk);
      a = if4.in_valid && if4.in_ready;
      @(posedge clk);
      #1;
      if (a) begin
        i++;
        acc4++;
      end
      n++;
    end
    if4.in_valid = 1'b0;
    chk("feed4_done", i, px.size());
  endtask

  px_q_t exp_ramp;

  task automatic cmp4(input string tag);
    chk({tag, "_count"}, got4.size(), 4);
    for (int i = 0; i < 4 && i < got4.size(); i++) begin
      chk({tag, "_data"}, got4[i], exp_ramp[i]);
      chk({tag, "_last"}, lastf4[i], (i == 3));
    end
  endtask

  px_t fr28 [2][28][28];

  initial begin
    vec_t  tbl[8];
    px_q_t ramp, part;
    int    idx, budget, n;
    bit    a;

    tbl[0] = mkv(-128,   -1,   -5, -100,   -1,   0);
    tbl[1] = mkv( 127,  127, -128,    0,  127, 127);
    tbl[2] = mkv(  -3,   -3,   -3,   -3,   -3,   0);
    tbl[3] = mkv(   5,   -7,    9, -128,    9,   9);
    tbl[4] = mkv(-128, -128, -128, -128, -128,   0);
    tbl[5] = mkv( -50,  -20,  -90,  -20,  -20,   0);
    tbl[6] = mkv(   0,   -1,   -1,   -1,    0,   0);
    tbl[7] = mkv(  -2,    3,   -4,    1,    3,   3);

    for (int i = 0; i < 16; i++) ramp.push_back(8'(i));
    for (int i = 0; i < 6; i++) part.push_back(8'(100 + i));
    exp_ramp = '{8'sd5, 8'sd7, 8'sd13, 8'sd15};

    reset = 1'b1; clr4 = 1'b0; clr28 = 1'b0;
    if4.in_valid = 1'b0; if4.in_data = '0; if4.out_ready = 1'b0;
    if28.in_valid = 1'b0; if28.in_data = '0; if28.out_ready = 1'b0;
    w2_valid = 1'b0; w2_data = '0; w2_ready = 1'b1;
    repeat (3) step();

    chk("rst_out_valid", if4.out_valid, 0);
    chk("rst_out_last", if4.out_last, 0);
    chk("rst_frame_done", if4.frame_done, 0);
    chk("rst_out_data", if4.out_data, 0);
    chk("rst_out_data28", if28.out_data, 0);
    reset = 1'b0;
    step();
    chk("rst_in_ready", if4.in_ready, 1);

    // signed windows on 2x2 frames, plain and ReLU, frames back-to-back
    for (int v = 0; v < 8; v++) begin
      for (int p = 0; p < 4; p++) begin
        w2_valid = 1'b1;
        case (p)
          0: w2_data = tbl[v].p0;
          1: w2_data = tbl[v].p1;
          2: w2_data = tbl[v].p2;
          default: w2_data = tbl[v].p3;
        endcase
        step();
      end
      w2_valid = 1'b0;
      chk("win_valid", if2a.out_valid, 1);
      chk("win_data", if2a.out_data, tbl[v].e0);
      chk("win_relu_data", if2b.out_data, tbl[v].e1);
      chk("win_last", if2a.out_last, 1);
      step();
      chk("win_done", if2a.frame_done, 1);
      chk("win_relu_done", if2b.frame_done, 1);
      chk("win_valid_clear", if2a.out_valid, 0);
    end

    // 4x4 ramp, free-flowing output
    if4.out_ready = 1'b1;
    feed4(ramp);
    repeat (4) step();
    cmp4("ramp");
    chk("ramp_done_cnt", done4_cnt, 1);
    chk("ramp_done_cycle", done4_cyc, last4_cyc + 1);

    // output held off after first result: input must stall, then resume cleanly
    got4.delete(); lastf4.delete(); done4_cnt = 0; acc4 = 0;
    if4.out_ready = 1'b0;
    fork
      feed4(ramp);
    join_none
    repeat (20) step();
    chk("stall_in_ready", if4.in_ready, 0);
    chk("stall_accepted", acc4, 6);
    chk("stall_out_valid", if4.out_valid, 1);
    chk("stall_out_data", if4.out_data, 5);
    chk("stall_no_emit", got4.size(), 0);
    if4.out_ready = 1'b1;
    wait fork;
    repeat (4) step();
    cmp4("stall");
    chk("stall_done_cnt", done4_cnt, 1);

    // clr with a pending result and an output handshake in the same cycle
    got4.delete(); lastf4.delete(); done4_cnt = 0;
    if4.out_ready = 1'b0;
    feed4(part);
    step();
    chk("clr_pending", if4.out_valid, 1);
    clr4 = 1'b1;
    if4.out_ready = 1'b1;
    #1;
    chk("clr_in_ready", if4.in_ready, 0);
    step();
    clr4 = 1'b0;
    chk("clr_out_valid", if4.out_valid, 0);
    chk("clr_out_last", if4.out_last, 0);
    chk("clr_no_emit", got4.size(), 0);
    feed4(ramp);
    repeat (4) step();
    cmp4("clr");

    // asynchronous reset mid-frame
    got4.delete(); lastf4.delete(); done4_cnt = 0;
    if4.out_ready = 1'b0;
    feed4(part);
    reset = 1'b1;
    #1;
    chk("arst_out_valid", if4.out_valid, 0);
    chk("arst_out_data", if4.out_data, 0);
    step();
    reset = 1'b0;
    step();
    got4.delete(); lastf4.delete();
    if4.out_ready = 1'b1;
    feed4(ramp);
    repeat (4) step();
    cmp4("arst");

    // randomized 28x28, two frames back-to-back
    for (int f = 0; f < 2; f++)
      for (int r = 0; r < 28; r++)
        for (int c = 0; c < 28; c++)
          fr28[f][r][c] = 8'($urandom);
    for (int f = 0; f < 2; f++)
      for (int r = 0; r < 14; r++)
        for (int c = 0; c < 14; c++) begin
          exp28.push_back(max2(max2(fr28[f][2*r][2*c],   fr28[f][2*r][2*c+1]),
                               max2(fr28[f][2*r+1][2*c], fr28[f][2*r+1][2*c+1])));
          explast28.push_back(r == 13 && c == 13);
        end

    idx = 0; budget = 0;
    while (idx < 1568 && budget < 40000) begin
      if28.in_valid  = ($urandom_range(0, 1) == 1);
      if28.in_data   = if28.in_valid ? fr28[idx / 784][(idx % 784) / 28][idx % 28]
                                     : 8'($urandom);
      if28.out_ready = ($urandom_range(0, 9) < 3);
      @(negedge clk);
      a = if28.in_valid && if28.in_ready;
      @(posedge clk);
      #1;
      if (a) idx++;
      budget++;
    end
    if28.in_valid  = 1'b0;
    if28.out_ready = 1'b1;
    chk("rand_fed", idx, 1568);
    n = 0;
    while (exp28.size() > 0 && n < 500) begin
      step();
      n++;
    end
    repeat (3) step();
    chk("rand_left", exp28.size(), 0);
    chk("rand_outputs", n_out28, 392);
    chk("rand_frame_done", done28, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/maxpool_stream.md
MAXPOOL_STREAM -- requirements
Module: maxpool_stream

Interface
REQ-001 SHALL have parameter IntSize, default 8: pixel width, two's-complement signed.
REQ-002 SHALL have parameter IMG_W, default 28: input frame width in pixels; even, >= 2.
REQ-003 SHALL have parameter IMG_H, default 28: input frame height in rows; even, >= 2.
REQ-004 SHALL have parameter RELU, default 0: 1 clamps negative results to 0.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  reset, asynchronous, active-high.
REQ-007 clr  input  1  synchronous frame abort; clears position state.
REQ-008 in_valid  input  1  upstream (conv) pixel valid.
REQ-009 in_ready  output  1  block accepts pixel this cycle.
REQ-010 in_data  input  IntSize  conv output pixel, raster order (row-major, top-left first).
REQ-011 out_valid  output  1  pooled pixel valid.
REQ-012 out_ready  input  1  downstream accepts pooled pixel.
REQ-013 out_data  output  IntSize  pooled pixel.
REQ-014 out_last  output  1  high with the final pooled pixel of a frame, i.e. (IMG_H/2-1, IMG_W/2-1).
REQ-015 frame_done  output  1  one-cycle pulse when the out_last beat is accepted.

Function
REQ-016 SHALL transfer an input beat only on a cycle where in_valid and in_ready are both 1; SHALL transfer an output beat only on a cycle where out_valid and out_ready are both 1.
REQ-017 in_ready SHALL equal !clr && (!out_valid || out_ready); no combinational path from in_valid to in_ready.
REQ-018 SHALL track col (0..IMG_W-1) and row (0..IMG_H-1); col increments per accepted beat, wraps to 0 and increments row; after (IMG_H-1, IMG_W-1), both wrap to 0.
REQ-019 Even col: SHALL hold in_data in a hold register.
REQ-020 Odd col: SHALL form pair = signed max(hold, in_data).
REQ-021 Even row, odd col: SHALL write pair into line buffer entry col/2 (IMG_W/2 entries); no output produced.
REQ-022 Odd row, odd col: SHALL load the output register with signed max(linebuf[col/2], pair), then apply ReLU if RELU=1; out_valid rises the next cycle (latency 1 cycle from the accepting edge).
REQ-023 Ties SHALL resolve to the equal value. Comparisons SHALL be signed at IntSize bits; no widening, no saturation.
REQ-024 out_data/out_last SHALL stay stable while out_valid=1 and out_ready=0.
REQ-025 out_valid SHALL clear on an accepted output beat unless a new result is loaded in the same cycle; with in_ready per REQ-017, simultaneous accept and load SHALL yield back-to-back valid.
REQ-026 out_last SHALL be set when loading the result from (row IMG_H-1, col IMG_W-1); frame_done SHALL pulse in the cycle after that beat is accepted.
REQ-027 Frame (IMG_H x IMG_W in) SHALL produce exactly (IMG_H/2)*(IMG_W/2) outputs in raster order; default 784 in -> 196 out.
REQ-028 A new frame SHALL be accepted immediately after wrap with no idle cycle required; line buffer contents SHALL be fully overwritten each even row, so no clearing is needed.
REQ-029 clr=1 SHALL reset row/col to 0, clear out_valid, out_last and frame_done, and drop any pending output; clr SHALL dominate a simultaneous input or output handshake.
REQ-030 in_valid gaps (bubbles) at any position SHALL NOT alter results.

Reset
REQ-031 On reset: row=0, col=0, out_valid=0, out_last=0, frame_done=0, out_data=0, hold=0; line buffer contents are not reset.
REQ-032 Reset asserted mid-frame SHALL discard the partial frame; first beat after release is treated as pixel (0,0).

Verification
REQ-033 IMG_W=IMG_H=4, in_data = 0..15 raster, out_ready=1 -> outputs 5,7,13,15; out_last with 15; frame_done one cycle later.
REQ-034 Signed, RELU=0: 2x2 window {-128,-1,-5,-100} -> -1; same with RELU=1 -> 0; window {127,127,-128,0} -> 127.
REQ-035 Default 28x28, two frames back-to-back, random data, in_valid random 50%, out_ready random 30% -> 392 outputs matching model; out_data stable under stall; exactly 2 frame_done pulses.
REQ-036 out_ready=0 held after first output -> in_ready low once out_valid=1, further beats rejected; release -> stream resumes, no loss or duplication.
REQ-037 clr (or reset) asserted after pixel (1,1) of a 4x4 frame, then full frame 0..15 -> outputs exactly 5,7,13,15; no stale output.
